// File: rtl/sha_word_window.sv
// Message-word window for the SHA-256 datapath: serially loads one DEPTH-word block,
// then streams words to the round core while an external expander refills the top tap.
//
// state | meaning
// IDLE  | window holds previous contents, waiting for the first word of a block
// LOAD  | collecting block words; load_cnt words accepted so far
// RUN   | emitting window[0] per handshake, refilling from fb_data
module sha_word_window #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ROUNDS = 64,
  parameter int CW     = 7
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [WIDTH-1:0]       fb_data,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CW-1:0]          round_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] win [DEPTH];
  logic [LW-1:0]    load_cnt;
  logic             load_acc;
  logic             run_acc;
  logic             load_last;
  logic             run_last;

  assign in_ready  = (state != RUN);
  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign out_data  = win[0];

  assign load_acc  = in_valid & in_ready;
  assign run_acc   = out_valid & out_ready;
  assign load_last = (load_cnt == LW'(DEPTH - 1));
  assign run_last  = (round_cnt == CW'(ROUNDS - 1));

  always_comb begin
    taps = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taps[i*WIDTH +: WIDTH] = win[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      load_cnt  <= '0;
      round_cnt <= '0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else if (clear) begin
      // Abort wins over any handshake presented in the same cycle.
      state     <= IDLE;
      load_cnt  <= '0;
      round_cnt <= '0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (load_acc) begin
            for (int i = 0; i < DEPTH - 1; i++) win[i] <= win[i+1];
            win[DEPTH-1] <= in_data;
            if (load_last) begin
              state     <= RUN;
              load_cnt  <= '0;
              round_cnt <= '0;
            end else begin
              state    <= LOAD;
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_acc) begin
            for (int i = 0; i < DEPTH - 1; i++) win[i] <= win[i+1];
            win[DEPTH-1] <= fb_data;
            if (run_last) begin
              // Window keeps its shifted contents until the next load.
              state     <= IDLE;
              round_cnt <= '0;
              done      <= 1'b1;
            end else begin
              round_cnt <= round_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
